// File: rtl/shift_pkg.sv
// Shared constants, request payload and FSM encoding for the shift issue stage.
package shift_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned AMT_W      = 32;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = 2;

    localparam logic SHIFT_RIGHT = 1'b0;
    localparam logic SHIFT_LEFT  = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } state_e;

    typedef struct packed {
        logic              dir;
        logic [AMT_W-1:0]  amt;
        logic [DATA_W-1:0] data;
    } shift_req_t;

    // Result of a shift whose amount is at least the data width.
    function automatic logic [DATA_W-1:0] clamp_result(input logic dir, input logic [DATA_W-1:0] data);
        return (dir == SHIFT_LEFT) ? '0 : {DATA_W{data[DATA_W-1]}};
    endfunction

endpackage

// File: rtl/shift_issue_stage_if.sv
// Request, shifter-side and result handshake signals of the shift issue stage.
interface shift_issue_stage_if;
    import shift_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_dir;
    logic [AMT_W-1:0]  in_amt;
    logic [DATA_W-1:0] in_data;
    logic              shf_dir;
    logic [AMT_W-1:0]  shf_amt;
    logic [DATA_W-1:0] shf_din;
    logic [DATA_W-1:0] shf_dout;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    modport slave (
        input  in_valid, in_dir, in_amt, in_data, shf_dout, out_ready,
        output in_ready, shf_dir, shf_amt, shf_din, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_dir, in_amt, in_data, shf_dout, out_ready,
        input  in_ready, shf_dir, shf_amt, shf_din, out_valid, out_data, busy
    );

endinterface

// File: rtl/shift_result_fifo.sv
// Two-entry result buffer with wrapping pointers; empty head reads as zero.
module shift_result_fifo
    import shift_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_W-1:0]     push_data_i,
    input  logic                  pop_i,
    output logic [FIFO_CNT_W-1:0] count_o,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     data_o
);

    logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push_i && !do_pop) begin
                count_q <= count_q + FIFO_CNT_W'(1);
            end else if (!push_i && do_pop) begin
                count_q <= count_q - FIFO_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/shift_issue_stage.sv
// Holds shift operands on the shifter for SETTLE_CYCLES, then captures the result.
// Optional SHIFT_ISSUE_CLAMP_EN: amounts >= 32 bypass the shifter with a local result.
module shift_issue_stage
    import shift_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    shift_issue_stage_if.slave sif
);

    state_e                state_q;
    logic [CNT_W-1:0]      settle_cnt_q;
    shift_req_t            shf_q;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_valid;
    logic [DATA_W-1:0]     fifo_data;
    logic [DATA_W-1:0]     push_data;
    logic [AMT_W-1:0]      amt_d;
    logic                  clamp_d;
    logic                  clamp_q;
    logic                  in_ready_c;
    logic                  accept;
    logic                  capture;
    logic                  pop;

    assign in_ready_c = (state_q == ST_IDLE) && (fifo_count < FIFO_CNT_W'(FIFO_DEPTH));
    assign accept     = in_ready_c && sif.in_valid;
    assign capture    = (state_q == ST_SETTLE) && (settle_cnt_q == '0);
    assign pop        = fifo_valid && sif.out_ready;

    // Amount presented to the shifter and source of the captured result.
    always_comb begin
        clamp_d   = 1'b0;
        amt_d     = sif.in_amt & AMT_W'(DATA_W - 1);
        push_data = sif.shf_dout;
`ifdef SHIFT_ISSUE_CLAMP_EN
        clamp_d = (sif.in_amt >= AMT_W'(DATA_W));
        if (clamp_d) begin
            amt_d = AMT_W'(DATA_W);
        end
        if (clamp_q) begin
            push_data = clamp_result(shf_q.dir, shf_q.data);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            shf_q        <= '0;
            clamp_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        shf_q        <= '{dir: sif.in_dir, amt: amt_d, data: sif.in_data};
                        clamp_q      <= clamp_d;
                        settle_cnt_q <= CNT_W'(SETTLE_CYCLES - 1);
                        state_q      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q != '0) begin
                        settle_cnt_q <= settle_cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    shift_result_fifo u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (capture),
        .push_data_i (push_data),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .valid_o     (fifo_valid),
        .data_o      (fifo_data)
    );

    assign sif.in_ready  = in_ready_c;
    assign sif.shf_dir   = shf_q.dir;
    assign sif.shf_amt   = shf_q.amt;
    assign sif.shf_din   = shf_q.data;
    assign sif.out_valid = fifo_valid;
    assign sif.out_data  = fifo_data;
    assign sif.busy      = (state_q == ST_SETTLE) || fifo_valid;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: two instances (settle 1 and 3) behind an ideal shifter.
module tb_shift_issue_stage;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    shift_issue_stage_if if1 ();
    shift_issue_stage_if if3 ();

    shift_issue_stage #(.SETTLE_CYCLES(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .sif(if1));
    shift_issue_stage #(.SETTLE_CYCLES(3)) u_dut3 (.clk_i(clk), .rst_i(rst), .sif(if3));

    function automatic logic [31:0] ideal_shift(input logic dir, input logic [31:0] amt, input logic [31:0] din);
        if (amt >= 32) return dir ? 32'h0 : {32{din[31]}};
        if (dir) return din << amt;
        return $signed(din) >>> amt;
    endfunction

    assign if1.shf_dout = ideal_shift(if1.shf_dir, if1.shf_amt, if1.shf_din);
    assign if3.shf_dout = ideal_shift(if3.shf_dir, if3.shf_amt, if3.shf_din);

    // Expected captured value, from the arithmetic meaning of each request.
    function automatic logic [31:0] exp_result(input logic dir, input logic [31:0] amt, input logic [31:0] data);
        int          k;
        longint      s;
        longint      p;
        logic [63:0] w;
`ifdef SHIFT_ISSUE_CLAMP_EN
        if (amt >= 32) return (dir == SHIFT_LEFT) ? 32'h0 : (data[31] ? 32'hFFFF_FFFF : 32'h0);
`endif
        k = int'(amt % 32);
        if (dir == SHIFT_LEFT) begin
            p = longint'({32'h0, data}) * (longint'(1) << k);
            w = 64'(p);
        end else begin
            s = longint'($signed(data));
            w = 64'(s >>> k);
        end
        return w[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic dir, input logic [31:0] amt, input logic [31:0] data);
        if (sel == 1) begin
            if1.in_valid = v; if1.in_dir = dir; if1.in_amt = amt; if1.in_data = data;
        end else begin
            if3.in_valid = v; if3.in_dir = dir; if3.in_amt = amt; if3.in_data = data;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 1) ? if1.in_ready : if3.in_ready;
    endfunction

    // Holds a request until accepted; returns just after the accepting edge.
    task automatic send(input int sel, input logic dir, input logic [31:0] amt, input logic [31:0] data, input string tag);
        logic done;
        done = 1'b0;
        drive(sel, 1'b1, dir, amt, data);
        for (int i = 0; i < 64 && !done; i++) begin
            if (rdy(sel)) done = 1'b1;
            step();
        end
        drive(sel, 1'b0, dir, amt, data);
        chk_b(tag, done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp;
        logic        r_dir;
        logic [31:0] r_amt, r_data;
        logic        acc, popd;
        int          got, issued;

        rst = 1'b1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 32'h0, 32'h0);
        if1.out_ready = 1'b0;
        if3.out_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset values
        chk_b("rst_in_ready1", if1.in_ready, 1'b1);
        chk_b("rst_out_valid1", if1.out_valid, 1'b0);
        chk_b("rst_busy1", if1.busy, 1'b0);
        chk("rst_out_data1", if1.out_data, 32'h0);
        chk("rst_shf_din1", if1.shf_din, 32'h0);
        chk("rst_shf_amt1", if1.shf_amt, 32'h0);
        chk_b("rst_shf_dir1", if1.shf_dir, 1'b0);
        chk_b("rst_in_ready3", if3.in_ready, 1'b1);
        chk_b("rst_busy3", if3.busy, 1'b0);

        // Single op, settle 1
        send(1, SHIFT_RIGHT, 32'd4, 32'h8000_00F0, "single_accept");
        chk("single_shf_din", if1.shf_din, 32'h8000_00F0);
        chk("single_shf_amt", if1.shf_amt, 32'd4);
        chk_b("single_in_ready_settle", if1.in_ready, 1'b0);
        chk_b("single_busy", if1.busy, 1'b1);
        chk_b("single_no_early_valid", if1.out_valid, 1'b0);
        step();
        chk_b("single_out_valid", if1.out_valid, 1'b1);
        chk("single_out_data", if1.out_data, 32'hF800_000F);
        chk_b("single_in_ready_back", if1.in_ready, 1'b1);
        if1.out_ready = 1'b1;
        step();
        if1.out_ready = 1'b0;
        chk_b("single_drained", if1.out_valid, 1'b0);
        chk_b("single_idle", if1.busy, 1'b0);

        // Back-to-back, settle 3, consumer always ready
        if3.out_ready = 1'b1;
        send(3, SHIFT_LEFT, 32'd1, 32'h0000_0001, "b2b_accept_a");
        drive(3, 1'b1, SHIFT_RIGHT, 32'd31, 32'h7FFF_FFFF);
        step();
        chk_b("b2b_e1_valid", if3.out_valid, 1'b0);
        chk_b("b2b_e1_ready", if3.in_ready, 1'b0);
        step();
        step();
        chk_b("b2b_a_valid", if3.out_valid, 1'b1);
        chk("b2b_a_data", if3.out_data, 32'h0000_0002);
        chk_b("b2b_ready_after_capture", if3.in_ready, 1'b1);
        step();
        drive(3, 1'b0, SHIFT_RIGHT, 32'd31, 32'h7FFF_FFFF);
        chk_b("b2b_a_popped", if3.out_valid, 1'b0);
        chk("b2b_b_shf_din", if3.shf_din, 32'h7FFF_FFFF);
        chk("b2b_b_shf_amt", if3.shf_amt, 32'd31);
        step(); step();
        chk_b("b2b_b_not_early", if3.out_valid, 1'b0);
        step();
        chk_b("b2b_b_valid", if3.out_valid, 1'b1);
        chk("b2b_b_data", if3.out_data, 32'h0000_0000);
        step();
        chk_b("b2b_done", if3.out_valid, 1'b0);
        chk_b("b2b_idle", if3.busy, 1'b0);
        if3.out_ready = 1'b0;

        // Backpressure: three random requests, consumer stalled
        for (int i = 0; i < 2; i++) begin
            r_dir  = 1'($urandom_range(0, 1));
            r_amt  = 32'($urandom_range(0, 63));
            r_data = $urandom;
            q.push_back(exp_result(r_dir, r_amt, r_data));
            send(1, r_dir, r_amt, r_data, "bp_accept");
        end
        exp    = r_data;
        r_dir  = 1'($urandom_range(0, 1));
        r_amt  = 32'($urandom_range(0, 31));
        r_data = $urandom;
        q.push_back(exp_result(r_dir, r_amt, r_data));
        drive(1, 1'b1, r_dir, r_amt, r_data);
        step();
        chk_b("bp_full_ready", if1.in_ready, 1'b0);
        chk_b("bp_full_busy", if1.busy, 1'b1);
        step();
        chk_b("bp_still_stalled", if1.in_ready, 1'b0);
        chk("bp_third_held", if1.shf_din, exp);
        chk_b("bp_head_valid", if1.out_valid, 1'b1);
        chk("bp_head0", if1.out_data, q.pop_front());
        if1.out_ready = 1'b1;
        step();
        chk_b("bp_ready_after_pop", if1.in_ready, 1'b1);
        got = 1;
        for (int c = 0; c < 40 && got < 3; c++) begin
            if (if1.out_valid) begin
                chk("bp_order", if1.out_data, q.pop_front());
                got++;
            end
            acc = if1.in_valid && if1.in_ready;
            step();
            if (acc) if1.in_valid = 1'b0;
        end
        chk("bp_count", 32'(got), 32'd3);
        chk_b("bp_no_dup", if1.out_valid, 1'b0);
        chk_b("bp_idle", if1.busy, 1'b0);
        if1.out_ready = 1'b0;

        // Simultaneous push and pop with one entry buffered
        send(1, SHIFT_LEFT, 32'd4, 32'h0000_0ABC, "pp_accept_x");
        step();
        chk("pp_x_head", if1.out_data, 32'h0000_ABC0);
        send(1, SHIFT_RIGHT, 32'd8, 32'h8765_4321, "pp_accept_y");
        if1.out_ready = 1'b1;
        chk("pp_x_before", if1.out_data, 32'h0000_ABC0);
        step();
        if1.out_ready = 1'b0;
        chk_b("pp_valid", if1.out_valid, 1'b1);
        chk("pp_y_head", if1.out_data, 32'hFF87_6543);
        step();
        chk_b("pp_count_one", if1.in_ready, 1'b1);
        chk("pp_y_stable", if1.out_data, 32'hFF87_6543);
        if1.out_ready = 1'b1;
        step();
        if1.out_ready = 1'b0;
        chk_b("pp_empty", if1.out_valid, 1'b0);

        // Out-of-range amounts
        send(1, SHIFT_RIGHT, 32'd40, 32'h8000_0001, "clamp_accept_r");
`ifdef SHIFT_ISSUE_CLAMP_EN
        chk("clamp_r_amt", if1.shf_amt, 32'd32);
        step();
        chk("clamp_r_data", if1.out_data, 32'hFFFF_FFFF);
`else
        chk("clamp_r_amt", if1.shf_amt, 32'd8);
        step();
        chk("clamp_r_data", if1.out_data, 32'hFF80_0000);
`endif
        if1.out_ready = 1'b1;
        step();
        if1.out_ready = 1'b0;
        send(1, SHIFT_LEFT, 32'd33, 32'h0000_000F, "clamp_accept_l");
        step();
`ifdef SHIFT_ISSUE_CLAMP_EN
        chk("clamp_l_data", if1.out_data, 32'h0000_0000);
`else
        chk("clamp_l_data", if1.out_data, 32'h0000_001E);
`endif
        chk_b("clamp_l_valid", if1.out_valid, 1'b1);
        if1.out_ready = 1'b1;
        step();
        if1.out_ready = 1'b0;

        // Random traffic with random backpressure against the model, settle 3
        q.delete();
        issued = 0;
        got    = 0;
        for (int c = 0; c < 3000 && got < 30; c++) begin
            if3.out_ready = 1'($urandom_range(0, 1));
            if (!if3.in_valid && issued < 30 && $urandom_range(0, 1) == 1) begin
                r_dir  = 1'($urandom_range(0, 1));
                r_amt  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
                r_data = $urandom;
                drive(3, 1'b1, r_dir, r_amt, r_data);
            end
            popd = if3.out_valid && if3.out_ready;
            acc  = if3.in_valid && if3.in_ready;
            if (popd) begin
                if (q.size() == 0) begin
                    chk_b("rnd_spurious", if3.out_valid, 1'b0);
                end else begin
                    chk("rnd_data", if3.out_data, q.pop_front());
                end
                got++;
            end
            if (acc) begin
                q.push_back(exp_result(r_dir, r_amt, r_data));
                issued++;
            end
            step();
            if (acc) if3.in_valid = 1'b0;
        end
        chk("rnd_received", 32'(got), 32'd30);
        chk("rnd_leftover", 32'(q.size()), 32'd0);
        if3.out_ready = 1'b0;
        step();

        // Reset mid-settle with one result buffered
        send(3, SHIFT_LEFT, 32'd3, 32'h0000_0005, "rst_accept_a");
        step(); step(); step();
        chk_b("rst_a_buffered", if3.out_valid, 1'b1);
        send(3, SHIFT_RIGHT, 32'd2, 32'h0000_1234, "rst_accept_b");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_b("rst_mid_out_valid", if3.out_valid, 1'b0);
        chk_b("rst_mid_busy", if3.busy, 1'b0);
        chk_b("rst_mid_in_ready", if3.in_ready, 1'b1);
        chk("rst_mid_shf_din", if3.shf_din, 32'h0);
        chk("rst_mid_out_data", if3.out_data, 32'h0);
        step(); step(); step();
        chk_b("rst_nothing_captured", if3.out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Registered issue/capture stage in front of the combinational 32-bit arithmetic shifter. It accepts shift requests over a valid/ready handshake and holds the operands stable on the shifter inputs for a programmable settle time. It then captures the shifter result into a 2-entry output buffer that drains over a second valid/ready handshake. It decouples the datapath sequencer from the shifter's long combinational path.

## Interface
- SETTLE_CYCLES, 1, cycles operands are held on the shifter before capture; legal range 1..15.
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- In_valid  in  1  request valid.
- In_ready  out  1  stage can accept a request this cycle.
- In_dir  in  1  0 = arithmetic right, 1 = left.
- In_amt  in  32  shift amount.
- In_data  in  32  operand.
- Shf_dir  out  1  registered direction to shifter.
- Shf_amt  out  32  registered amount to shifter.
- Shf_din  out  32  registered operand to shifter.
- Shf_dout  in  32  shifter result.
- Out_valid  out  1  buffer head valid.
- Out_ready  in  1  consumer accepts head.
- Out_data  out  32  buffer head result.
- Busy  out  1  request in flight or buffer non-empty.

## Operation
- FSM: IDLE, SETTLE.
- IDLE: In_ready = (buf_count < 2). On In_valid && In_ready: load Shf_dir/Shf_amt/Shf_din, settle_cnt <= SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: In_ready = 0. If settle_cnt != 0, decrement. If settle_cnt == 0, push Shf_dout into the buffer and go to IDLE.
- Shf_* registers hold their last value in IDLE; they change only on acceptance.
- Buffer: 2-entry FIFO with wrapping 1-bit read/write pointers and a 2-bit count. Pop on Out_valid && Out_ready. Push and pop in the same cycle leave the count unchanged.
- Only one request is ever in flight, and acceptance requires count < 2. A capture therefore never meets a full buffer. No overflow path exists.
- Out_valid = (count != 0). Out_data = entry at the read pointer. Out_data is 0 when the buffer is empty.
- Busy = (state == SETTLE) || (count != 0).

## Timing
- Acceptance at edge E0. Shf_* are valid from E0. Capture at edge E(SETTLE_CYCLES). Out_valid is high in the cycle after capture.
- Latency: SETTLE_CYCLES edges from acceptance to Out_valid.
- Maximum throughput: one request per SETTLE_CYCLES+1 cycles. In_ready returns high the cycle after capture if count < 2.
- In_ready is combinational from state and count only, never from In_valid.
- Out_ready held low: after two captures In_ready = 0. A pop at edge E restores In_ready in the following cycle.
- Reset values: state IDLE, Shf_dir 0, Shf_amt 0, Shf_din 0, buffer empty, Out_valid 0, Out_data 0, Busy 0, In_ready 1.
- Rst asserted mid-SETTLE or with a non-empty buffer: the in-flight request and all buffered results are discarded. Nothing is captured at that edge.

## Configuration
- SHIFT_ISSUE_CLAMP_EN defined:
  - When In_amt >= 32, the stage bypasses the shifter and pushes a locally computed result at capture.
  - Right shift: {32{In_data[31]}}.
  - Left shift: 0.
  - Latency is unchanged. Shf_amt is loaded with 32.
- Undefined: Shf_amt = {27'b0, In_amt[4:0]}, and the shifter result is always captured.

## Structure
- Shared package shift_pkg holds:
  - Direction constants SHIFT_RIGHT = 1'b0 and SHIFT_LEFT = 1'b1.
  - Data width constant 32.
  - FSM state encoding.
- One natural sub-module: shift_result_fifo, the 2-entry buffer with push, pop, count, head data and reset.

## Test plan
The bench models the shifter as ideal: right = >>> (sign fill), left = << (zero fill).
- Single op, SETTLE_CYCLES=1: In_dir=0, In_amt=4, In_data=0x8000_00F0 -> Out_valid 1 edge after acceptance, Out_data=0xF800_000F.
- Back-to-back with Out_ready held high, SETTLE_CYCLES=3: left by 1 of 0x0000_0001, then right by 31 of 0x7FFF_FFFF -> results 0x0000_0002 then 0x0000_0000, spaced 4 cycles apart.
- Backpressure, Out_ready=0: three requests issued -> two captured, In_ready=0, third held. Raise Out_ready -> all three drain in order, with no loss or duplication.
- Simultaneous push and pop with count=1 -> count stays 1 and order is preserved.
- Clamp: In_dir=0, In_amt=40, In_data=0x8000_0001:
  - With SHIFT_ISSUE_CLAMP_EN -> 0xFFFF_FFFF.
  - Without it -> Shf_amt=8 and result 0xFF80_0000.
- Rst asserted in SETTLE with one result buffered -> next cycle Out_valid=0, Busy=0, In_ready=1, Shf_din=0.
